pacman_motion: RTL and testbench
================================

// Module: pacman_motion
// PURPOSE
//  Tile-level Pac-Man movement controller, directly upstream of the maze wall ROM.
//  Drives pacman_index into the maze and consumes the registered adjacent_walls reply.
//  On each move_tick it decides whether to turn, continue or stop, then steps one tile.
//  Buffers the latest player direction request until it can be taken (pre-turning).
// PARAMETERS
//  GRID_W     40  tiles per row; index = y*GRID_W + x
//  GRID_H     30  tiles per column (GRID_W*GRID_H = 1200 = maze depth)
//  START_X    20  x tile after reset
//  START_Y    22  y tile after reset
//  START_DIR  2   direction after reset (0=up 1=down 2=left 3=right)
// PORTS
//  Clk             in   1   system clock
//  Reset           in   1   synchronous, active-high reset
//  move_tick       in   1   1-cycle pulse; request one step (frame-rate)
//  req_valid       in   1   1-cycle pulse; req_dir is a new player request
//  req_dir         in   2   requested direction (0=up 1=down 2=left 3=right)
//  adjacent_walls  in   4   from maze, 1 cycle after pacman_index; [3]=up [2]=down [1]=left [0]=right, 1=wall
//  pacman_index    out  11  current tile index to maze, registered
//  pacman_x        out  6   current x tile, registered
//  pacman_y        out  5   current y tile, registered
//  dir             out  2   current heading
//  moving          out  1   1 = last decision stepped; 0 = blocked
//  step_done       out  1   1-cycle pulse when a decision completes (moved or blocked)
// BEHAVIOUR
//  Reset (sync, any state): x=START_X, y=START_Y, pacman_index=START_Y*GRID_W+START_X,
//   dir=START_DIR, moving=0, step_done=0, pending request cleared, FSM->SETTLE.
//  pacman_index always equals y*GRID_W+x; it updates in the same cycle as x/y.
//  Request buffer: req_valid loads req_dir into pend_dir and sets pend_v (newest wins).
//   If req_valid coincides with CHECK, CHECK uses the old pend value; the new one is stored after.
//  FSM (one-hot or encoded, 4 states):
//   SETTLE: 1 cycle; lets maze output catch up to new pacman_index -> IDLE.
//   IDLE:   move_tick=1 -> CHECK; else stay.
//   CHECK:  uses adjacent_walls (valid for current tile):
//     pend_v && !wall[pend_dir]  -> dir<=pend_dir, pend_v<=0, go MOVE.
//     else !wall[dir]            -> go MOVE (pend_v kept).
//     else                       -> moving<=0, step_done<=1, go IDLE.
//   MOVE:   step one tile in dir, moving<=1, step_done<=1, go SETTLE.
//  Latency: move_tick in IDLE at cycle N -> CHECK N+1 -> new x/y/index and step_done at N+3
//   (blocked: step_done at N+2, position unchanged).
//  move_tick outside IDLE is ignored (dropped, not queued).
//  Wrap-around: left at x=0 -> x=GRID_W-1; right at x=GRID_W-1 -> x=0;
//   up at y=0 -> y=GRID_H-1; down at y=GRID_H-1 -> y=0. No out-of-range index is ever driven.
//  Wall bit select: up->[3], down->[2], left->[1], right->[0].
//  Reversal needs no special case; same wall test applies.
// TESTING
//  1 Reset, walls=0000, one tick -> x 20->19, index 900->899, step_done at tick+3, moving=1.
//  2 Walls=0010 (left wall), tick -> step_done at tick+2, x stays 20, moving=0, dir=2.
//  3 req up while walls=1000, tick -> continue left, pend_v held; next tile walls=0000, tick -> dir=0, y 22->21.
//  4 x=0 heading left, walls=0000, tick -> x=39, index=y*40+39; y=29 heading down -> y=0.
//  5 Ticks on consecutive cycles -> only first causes a step; extra ticks dropped.
//  6 Reset asserted in MOVE -> next cycle x=20,y=22,index=900,dir=2,moving=0,no step_done.

Source files
------------

// File: rtl/pacman_motion.sv
// Tile-level Pac-Man movement controller. Presents the current tile index to
// the maze wall ROM, waits for its registered wall reply, then on each
// move_tick decides to turn (buffered player request), continue, or stop.
module pacman_motion #(
  parameter int         GRID_W    = 40,
  parameter int         GRID_H    = 30,
  parameter int         START_X   = 20,
  parameter int         START_Y   = 22,
  parameter logic [1:0] START_DIR = 2'd2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        move_tick,
  input  logic        req_valid,
  input  logic [1:0]  req_dir,
  input  logic [3:0]  adjacent_walls,
  output logic [10:0] pacman_index,
  output logic [5:0]  pacman_x,
  output logic [4:0]  pacman_y,
  output logic [1:0]  dir,
  output logic        moving,
  output logic        step_done
);

  localparam logic [1:0]  DIR_UP    = 2'd0;
  localparam logic [1:0]  DIR_DOWN  = 2'd1;
  localparam logic [1:0]  DIR_LEFT  = 2'd2;
  localparam logic [1:0]  DIR_RIGHT = 2'd3;

  localparam logic [5:0]  X_MAX     = 6'(GRID_W - 1);
  localparam logic [4:0]  Y_MAX     = 5'(GRID_H - 1);
  localparam logic [5:0]  X_START   = 6'(START_X);
  localparam logic [4:0]  Y_START   = 5'(START_Y);
  localparam logic [10:0] IDX_START = 11'(START_Y * GRID_W + START_X);
  localparam logic [10:0] ROW_LEN   = 11'(GRID_W);

  typedef enum logic [1:0] {
    S_SETTLE,
    S_IDLE,
    S_CHECK,
    S_MOVE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  r_x;
  logic [4:0]  r_y;
  logic [10:0] r_index;
  logic [1:0]  r_dir;
  logic        r_moving;
  logic        r_step_done;
  logic        r_pend_v;
  logic [1:0]  r_pend_dir;

  logic        w_take_pend;
  logic        w_go;
  logic [5:0]  w_x_next;
  logic [4:0]  w_y_next;
  logic [10:0] w_index_next;

  // Wall bits are ordered up,down,left,right from MSB, i.e. bit = 3 - dir.
  function automatic logic wall_for(input logic [3:0] walls, input logic [1:0] d);
    return walls[~d];
  endfunction

  assign w_take_pend = r_pend_v && !wall_for(adjacent_walls, r_pend_dir);
  assign w_go        = w_take_pend || !wall_for(adjacent_walls, r_dir);

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_SETTLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state: settle one cycle after every move so the maze reply
  // matches the new index; ticks outside IDLE are simply not looked at.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SETTLE: w_state_next = S_IDLE;
      S_IDLE:   if (move_tick) w_state_next = S_CHECK;
      S_CHECK:  w_state_next = w_go ? S_MOVE : S_IDLE;
      S_MOVE:   w_state_next = S_SETTLE;
      default:  w_state_next = S_SETTLE;
    endcase
  end

  // Next tile one step along the current heading, wrapping at the edges.
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    case (r_dir)
      DIR_UP:    w_y_next = (r_y == 5'd0)  ? Y_MAX : r_y - 5'd1;
      DIR_DOWN:  w_y_next = (r_y == Y_MAX) ? 5'd0  : r_y + 5'd1;
      DIR_LEFT:  w_x_next = (r_x == 6'd0)  ? X_MAX : r_x - 6'd1;
      DIR_RIGHT: w_x_next = (r_x == X_MAX) ? 6'd0  : r_x + 6'd1;
      default:   w_x_next = r_x;
    endcase
    w_index_next = 11'(w_y_next) * ROW_LEN + 11'(w_x_next);
  end

  // Position, heading, status and request buffer. A request arriving in
  // CHECK is written after the decision, so it overrides any pend clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x         <= X_START;
      r_y         <= Y_START;
      r_index     <= IDX_START;
      r_dir       <= START_DIR;
      r_moving    <= 1'b0;
      r_step_done <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_dir  <= '0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        S_CHECK: begin
          if (w_take_pend) begin
            r_dir    <= r_pend_dir;
            r_pend_v <= 1'b0;
          end else if (!w_go) begin
            r_moving    <= 1'b0;
            r_step_done <= 1'b1;
          end
        end
        S_MOVE: begin
          r_x         <= w_x_next;
          r_y         <= w_y_next;
          r_index     <= w_index_next;
          r_moving    <= 1'b1;
          r_step_done <= 1'b1;
        end
        default: ;
      endcase
      if (req_valid) begin
        r_pend_v   <= 1'b1;
        r_pend_dir <= req_dir;
      end
    end
  end

  assign pacman_index = r_index;
  assign pacman_x     = r_x;
  assign pacman_y     = r_y;
  assign dir          = r_dir;
  assign moving       = r_moving;
  assign step_done    = r_step_done;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: reset state, move/block latency, buffered
// turns, edge wrap-around, dropped ticks and reset in the middle of a move.
module tb_pacman_motion;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        move_tick = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_dir = 2'd0;
  logic [3:0]  adjacent_walls = 4'b0000;
  logic [10:0] pacman_index;
  logic [5:0]  pacman_x;
  logic [4:0]  pacman_y;
  logic [1:0]  dir;
  logic        moving;
  logic        step_done;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int pulses;

  pacman_motion #(
    .GRID_W(40), .GRID_H(30), .START_X(20), .START_Y(22), .START_DIR(2'd2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .move_tick(move_tick), .req_valid(req_valid),
    .req_dir(req_dir), .adjacent_walls(adjacent_walls),
    .pacman_index(pacman_index), .pacman_x(pacman_x), .pacman_y(pacman_y),
    .dir(dir), .moving(moving), .step_done(step_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // Pulse move_tick for one cycle and count cycles until step_done (99 = never).
  task automatic tick_wait(output int l);
    @(negedge Clk); move_tick = 1'b1;
    l = 99;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk); move_tick = 1'b0;
      if (step_done === 1'b1) begin l = c; break; end
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic request(input logic [1:0] d);
    @(negedge Clk); req_valid = 1'b1; req_dir = d;
    @(negedge Clk); req_valid = 1'b0;
  endtask

  initial begin
    // 1: reset values, then a free step left
    do_reset();
    chk("rst_x", pacman_x, 20);
    chk("rst_y", pacman_y, 22);
    chk("rst_idx", pacman_index, 900);
    chk("rst_dir", dir, 2);
    chk("rst_moving", moving, 0);
    chk("rst_done", step_done, 0);
    adjacent_walls = 4'b0000;
    tick_wait(lat);
    chk("t1_lat", lat, 3);
    chk("t1_x", pacman_x, 19);
    chk("t1_idx", pacman_index, 899);
    chk("t1_moving", moving, 1);

    // 2: blocked by a left wall
    do_reset();
    adjacent_walls = 4'b0010;
    tick_wait(lat);
    chk("t2_lat", lat, 2);
    chk("t2_x", pacman_x, 20);
    chk("t2_idx", pacman_index, 900);
    chk("t2_moving", moving, 0);
    chk("t2_dir", dir, 2);

    // 3: up request blocked -> keep going left, turn once up is open
    request(2'd0);
    adjacent_walls = 4'b1000;
    tick_wait(lat);
    chk("t3a_lat", lat, 3);
    chk("t3a_x", pacman_x, 19);
    chk("t3a_dir", dir, 2);
    adjacent_walls = 4'b0000;
    tick_wait(lat);
    chk("t3b_lat", lat, 3);
    chk("t3b_dir", dir, 0);
    chk("t3b_y", pacman_y, 21);
    chk("t3b_x", pacman_x, 19);
    chk("t3b_idx", pacman_index, 859);

    // 4: wrap left at x=0, then wrap down at y=29
    request(2'd2);
    for (int i = 0; i < 19; i++) tick_wait(lat);
    chk("t4_x0", pacman_x, 0);
    chk("t4_dir", dir, 2);
    tick_wait(lat);
    chk("t4_xwrap", pacman_x, 39);
    chk("t4_idxwrap", pacman_index, 879);
    request(2'd1);
    for (int i = 0; i < 8; i++) tick_wait(lat);
    chk("t4_y29", pacman_y, 29);
    chk("t4_idx29", pacman_index, 1199);
    tick_wait(lat);
    chk("t4_ywrap", pacman_y, 0);
    chk("t4_idxywrap", pacman_index, 39);

    // 5: tick held four cycles -> exactly one step
    pulses = 0;
    @(negedge Clk); move_tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (c == 4) move_tick = 1'b0;
      if (step_done === 1'b1) pulses++;
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_y", pacman_y, 1);
    chk("t5_idx", pacman_index, 79);

    // 6: reset asserted while in MOVE
    @(negedge Clk); move_tick = 1'b1;
    @(negedge Clk); move_tick = 1'b0;   // CHECK
    @(negedge Clk); Reset = 1'b1;       // MOVE
    @(negedge Clk);
    chk("t6_x", pacman_x, 20);
    chk("t6_y", pacman_y, 22);
    chk("t6_idx", pacman_index, 900);
    chk("t6_dir", dir, 2);
    chk("t6_moving", moving, 0);
    chk("t6_done", step_done, 0);
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
